// File: rtl/multicycle_control_if.sv
// Control/datapath bundle of the multi-cycle RV32I core: decode inputs
// toward the control FSM, mux selects and strobes back to the datapath.
interface multicycle_control_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       OPCODE;
   logic             BRANCH_TAKEN;
   logic             MEM_READY;
   logic [2:0]       ALUOP;
   logic [1:0]       ALUSRCA;
   logic [1:0]       ALUSRCB;
   logic             PCSOURCE;
   logic             IORD;
   logic [1:0]       MEMTOREG;
   logic             PCWRITE;
   logic             IRWRITE;
   logic             MEMREAD;
   logic             MEMWRITE;
   logic             REGWRITE;
   logic             ILLEGAL;
   logic [3:0]       STATE;
   logic [CNT_W-1:0] RETIRED;

   modport master (
      input  OPCODE, BRANCH_TAKEN, MEM_READY,
      output ALUOP, ALUSRCA, ALUSRCB, PCSOURCE, IORD, MEMTOREG,
             PCWRITE, IRWRITE, MEMREAD, MEMWRITE, REGWRITE,
             ILLEGAL, STATE, RETIRED
   );

   modport slave (
      output OPCODE, BRANCH_TAKEN, MEM_READY,
      input  ALUOP, ALUSRCA, ALUSRCB, PCSOURCE, IORD, MEMTOREG,
             PCWRITE, IRWRITE, MEMREAD, MEMWRITE, REGWRITE,
             ILLEGAL, STATE, RETIRED
   );
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core: sequences one shared ALU
// and one shared memory port, stretches memory states on MEM_READY.
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input logic                  CLK,
   input logic                  RESET,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_JAL    = 4'd10,
      S_EXEC_U = 4'd11,
      S_HALT   = 4'd15
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t           state;
   logic             illegal;
   logic [CNT_W-1:0] retired;
   logic             retire;

   // Every path that ends an instruction lands back in FETCH through here.
   always_comb begin
      retire = 1'b0;
      case (state)
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: retire = 1'b1;
         S_MEM_WR:                            retire = bus.MEM_READY;
         default:                             retire = 1'b0;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= S_FETCH;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         if (retire) begin
            retired <= retired + CNT_W'(1);
         end
         case (state)
            S_FETCH: begin
               if (bus.MEM_READY) begin
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               case (bus.OPCODE)
                  OP_R:               state <= S_EXEC_R;
                  OP_I:               state <= S_EXEC_I;
                  OP_LOAD, OP_STORE:  state <= S_ADDR;
                  OP_BRANCH:          state <= S_BRANCH;
                  OP_JAL:             state <= S_JAL;
                  OP_LUI, OP_AUIPC:   state <= S_EXEC_U;
                  default: begin
                     state   <= S_HALT;
                     illegal <= 1'b1;
                  end
               endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_U: state <= S_WB_ALU;
            S_ADDR: begin
               state <= (bus.OPCODE == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               if (bus.MEM_READY) begin
                  state <= S_WB_MEM;
               end
            end
            S_MEM_WR: begin
               if (bus.MEM_READY) begin
                  state <= S_FETCH;
               end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            // Unused encodings recover to a clean fetch.
            default: state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      bus.ALUOP    = 3'b000;
      bus.ALUSRCA  = 2'b00;
      bus.ALUSRCB  = 2'b00;
      bus.PCSOURCE = 1'b0;
      bus.IORD     = 1'b0;
      bus.MEMTOREG = 2'b00;
      bus.PCWRITE  = 1'b0;
      bus.IRWRITE  = 1'b0;
      bus.MEMREAD  = 1'b0;
      bus.MEMWRITE = 1'b0;
      bus.REGWRITE = 1'b0;
      case (state)
         S_FETCH: begin
            bus.MEMREAD = 1'b1;
            bus.ALUSRCB = 2'b01;
            bus.ALUOP   = 3'b010;
            bus.IRWRITE = bus.MEM_READY;
            bus.PCWRITE = bus.MEM_READY;
         end
         // Branch/JAL target computed speculatively from OLDPC + IMM.
         S_DECODE: begin
            bus.ALUSRCA = 2'b10;
            bus.ALUSRCB = 2'b10;
            bus.ALUOP   = 3'b010;
         end
         S_EXEC_R: begin
            bus.ALUSRCA = 2'b01;
            bus.ALUSRCB = 2'b00;
            bus.ALUOP   = 3'b000;
         end
         S_EXEC_I: begin
            bus.ALUSRCA = 2'b01;
            bus.ALUSRCB = 2'b10;
            bus.ALUOP   = 3'b001;
         end
         S_EXEC_U: begin
            bus.ALUSRCB = 2'b10;
            if (bus.OPCODE == OP_LUI) begin
               bus.ALUSRCA = 2'b11;
               bus.ALUOP   = 3'b101;
            end else begin
               bus.ALUSRCA = 2'b10;
               bus.ALUOP   = 3'b110;
            end
         end
         S_ADDR: begin
            bus.ALUSRCA = 2'b01;
            bus.ALUSRCB = 2'b10;
            bus.ALUOP   = (bus.OPCODE == OP_LOAD) ? 3'b010 : 3'b011;
         end
         S_MEM_RD: begin
            bus.MEMREAD = 1'b1;
            bus.IORD    = 1'b1;
         end
         S_MEM_WR: begin
            bus.MEMWRITE = 1'b1;
            bus.IORD     = 1'b1;
         end
         S_WB_ALU: begin
            bus.REGWRITE = 1'b1;
            bus.MEMTOREG = 2'b00;
         end
         S_WB_MEM: begin
            bus.REGWRITE = 1'b1;
            bus.MEMTOREG = 2'b01;
         end
         S_BRANCH: begin
            bus.ALUSRCA  = 2'b01;
            bus.ALUSRCB  = 2'b00;
            bus.ALUOP    = 3'b100;
            bus.PCSOURCE = 1'b1;
            bus.PCWRITE  = bus.BRANCH_TAKEN;
         end
         S_JAL: begin
            bus.PCSOURCE = 1'b1;
            bus.PCWRITE  = 1'b1;
            bus.REGWRITE = 1'b1;
            bus.MEMTOREG = 2'b10;
         end
         default: ;
      endcase
      // Reset must silence writes immediately, even mid memory access.
      if (RESET) begin
         bus.PCWRITE  = 1'b0;
         bus.IRWRITE  = 1'b0;
         bus.MEMWRITE = 1'b0;
         bus.REGWRITE = 1'b0;
      end
   end

   assign bus.STATE   = state;
   assign bus.ILLEGAL = illegal;
   assign bus.RETIRED = retired;

endmodule
